// File: rtl/i2s_transmit1.sv
// i2s_transmit1: I2S transmitter running in the bit-clock domain.
// Takes one left/right pair per frame through a single-entry holding
// register and emits 64-bit frames (two 32-bit slots, MSB first) with
// word select leading the data by one bit.
module i2s_transmit1 #(
    parameter int DATA_W = 32
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    output logic              ws,
    output logic              sd,
    output logic              frame_start,
    output logic              underrun
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Frame sequencer state; r_pos is the bit position currently on sd/ws.
    state_t      r_state;
    logic [5:0]  r_pos;
    logic [63:0] r_shift;
    logic        r_ws;
    logic        r_sd;
    logic        r_frame_start;
    logic        r_underrun;

    // Single-entry holding register between the source and the sequencer.
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_left;
    logic [DATA_W-1:0] r_hold_right;

    logic        w_load;
    logic        w_advance;
    logic        w_accept;
    logic [5:0]  w_next_pos;
    logic        w_next_ws;
    logic [63:0] w_frame;

    // Left-justify a sample in its 32-bit slot; unused LSBs are zero.
    function automatic logic [31:0] slot_word(input logic [DATA_W-1:0] s);
        logic [31:0] w;
        w = '0;
        w[31 -: DATA_W] = s;
        return w;
    endfunction

    // Word select for a given bit position: high one bit ahead of the
    // right slot and dropping one bit ahead of the next left slot.
    function automatic logic ws_for_pos(input logic [5:0] pos);
        return (pos >= 6'd31) && (pos <= 6'd62);
    endfunction

    // A new frame starts on leaving IDLE with en high, or at the end of a
    // frame when en is still high. en is otherwise only looked at here, so
    // a mid-frame drop always lets the current frame finish.
    assign w_load     = en && ((r_state == S_IDLE) ||
                               ((r_state == S_RUN) && (r_pos == 6'd63)));
    assign w_advance  = (r_state == S_RUN) && (r_pos != 6'd63);
    assign w_accept   = in_valid && !r_hold_full;
    assign w_next_pos = r_pos + 6'd1;
    assign w_next_ws  = ws_for_pos(w_next_pos);

    // The frame contents come only from what is already held; an empty
    // hold yields an all-zero frame (a same-edge accept is not bypassed).
    assign w_frame = r_hold_full ? {slot_word(r_hold_left), slot_word(r_hold_right)}
                                 : 64'd0;

    // Frame sequencer: loads, shifts and drives the registered outputs.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pos         <= 6'd0;
            r_shift       <= 64'd0;
            r_ws          <= 1'b0;
            r_sd          <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else if (w_load) begin
            // Present bit 0: MSB out now, remaining bits queued.
            r_state       <= S_RUN;
            r_pos         <= 6'd0;
            r_shift       <= {w_frame[62:0], 1'b0};
            r_sd          <= w_frame[63];
            r_ws          <= 1'b0;
            r_frame_start <= 1'b1;
            r_underrun    <= !r_hold_full;
        end else if (w_advance) begin
            r_pos         <= w_next_pos;
            r_shift       <= {r_shift[62:0], 1'b0};
            r_sd          <= r_shift[63];
            r_ws          <= w_next_ws;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            // Idle, or a frame just completed with en low.
            r_state       <= S_IDLE;
            r_pos         <= 6'd0;
            r_shift       <= 64'd0;
            r_sd          <= 1'b0;
            r_ws          <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end
    end

    // Hold occupancy: emptied by a frame load, filled by an accepted pair.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            r_hold_full <= 1'b0;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
        end
    end

    // Hold data: only meaningful while r_hold_full is set, so no reset.
    always_ff @(posedge sck) begin
        if (w_accept) begin
            r_hold_left  <= in_left;
            r_hold_right <= in_right;
        end
    end

    assign in_ready    = !r_hold_full;
    assign ws          = r_ws;
    assign sd          = r_sd;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_transmit1.sv
// tb_i2s_transmit1: directed bench for the I2S transmitter (DATA_W 32 and 24).
module tb_i2s_transmit1;

    localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE; // ws high at p31..62
    localparam logic [63:0] P0_EXP = 64'h8000_0000_0000_0000; // only p0 set

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, in_valid = 1'b0;
    logic [31:0] in_left = '0, in_right = '0;
    logic        in_ready, ws, sd, fs, ur;

    logic        en2 = 1'b0, v2 = 1'b0;
    logic [23:0] l2 = '0, r2 = '0;
    logic        rdy2, ws2, sd2, fs2, ur2;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] bl [8] = '{32'h0101_0101, 32'h2222_0000, 32'h8000_0001, 32'hFFFF_FFFF,
                            32'h1234_5678, 32'h0000_0000, 32'hCAFE_BABE, 32'h7FFF_FFFE};
    logic [31:0] br [8] = '{32'h1010_1010, 32'h0000_3333, 32'h0F0F_0F0F, 32'h0000_0001,
                            32'h8765_4321, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h5555_AAAA};

    always #5 sck = ~sck;

    i2s_transmit1 #(.DATA_W(32)) dut (
        .sck(sck), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .ws(ws), .sd(sd),
        .frame_start(fs), .underrun(ur)
    );

    i2s_transmit1 #(.DATA_W(24)) dut24 (
        .sck(sck), .rst(rst), .en(en2), .in_valid(v2), .in_ready(rdy2),
        .in_left(l2), .in_right(r2), .ws(ws2), .sd(sd2),
        .frame_start(fs2), .underrun(ur2)
    );

    // Wait for the next frame_start (sampled on falling sck) and record the
    // 64 periods of the frame, p0 in bit 63. Optionally drops en at drop_at.
    task automatic capture(input int which, input int drop_at,
                           output logic [63:0] sdw, output logic [63:0] wsw,
                           output logic [63:0] fsw, output logic [63:0] urw,
                           output int nwait, output bit to);
        logic f;
        sdw = '0; wsw = '0; fsw = '0; urw = '0; nwait = 0; to = 1'b0;
        do begin
            @(negedge sck);
            nwait++;
            f = (which == 0) ? fs : fs2;
        end while (f !== 1'b1 && nwait < 200);
        if (f !== 1'b1) begin
            to = 1'b1;
            return;
        end
        for (int p = 0; p < 64; p++) begin
            if (p > 0) @(negedge sck);
            if (p == drop_at) en = 1'b0;
            sdw[63-p] = (which == 0) ? sd : sd2;
            wsw[63-p] = (which == 0) ? ws : ws2;
            fsw[63-p] = (which == 0) ? fs : fs2;
            urw[63-p] = (which == 0) ? ur : ur2;
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        in_valid = 1'b0;
        repeat (70) @(negedge sck);
    endtask

    task automatic test_reset();
        #23;
        n_assert++; if (ws !== 1'b0 || sd !== 1'b0) begin n_fail++;
            $display("FAIL rst_ws_sd: got ws=%b sd=%b, want 0 0", ws, sd); end
        n_assert++; if (in_ready !== 1'b1 || rdy2 !== 1'b1) begin n_fail++;
            $display("FAIL rst_in_ready: got %b/%b, want 1/1", in_ready, rdy2); end
        n_assert++; if (fs !== 1'b0 || ur !== 1'b0) begin n_fail++;
            $display("FAIL rst_fs_ur: got fs=%b ur=%b, want 0 0", fs, ur); end
        @(negedge sck);
        rst = 1'b0;
        repeat (4) @(negedge sck);
        n_assert++; if ({ws, sd, fs, ur, in_ready} !== 5'b00001) begin n_fail++;
            $display("FAIL idle_after_rst: got ws,sd,fs,ur,rdy=%b, want 00001",
                     {ws, sd, fs, ur, in_ready}); end
    endtask

    task automatic test_single_pair();
        logic [63:0] s, w, f, u; int nw; bit to;
        in_valid = 1'b1; in_left = 32'hA5A5_0F0F; in_right = 32'h1234_5678;
        @(negedge sck);
        in_valid = 1'b0;
        n_assert++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL single_ready_after_accept: got %b, want 0", in_ready); end
        en = 1'b1;
        capture(0, -1, s, w, f, u, nw, to);
        n_assert++; if (to) begin n_fail++;
            $display("FAIL single_timeout: no frame_start within 200 periods"); end
        n_assert++; if (nw !== 1) begin n_fail++;
            $display("FAIL single_latency: got %0d periods, want 1", nw); end
        n_assert++; if (s !== 64'hA5A5_0F0F_1234_5678) begin n_fail++;
            $display("FAIL single_sd: got %h, want a5a50f0f12345678", s); end
        n_assert++; if (w !== WS_EXP) begin n_fail++;
            $display("FAIL single_ws: got %h, want %h", w, WS_EXP); end
        n_assert++; if (f !== P0_EXP || u !== 64'd0) begin n_fail++;
            $display("FAIL single_fs_ur: got fs=%h ur=%h, want %h 0", f, u, P0_EXP); end
        n_assert++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL single_ready_after_load: got %b, want 1", in_ready); end
    endtask

    task automatic test_underrun();
        logic [63:0] s, w, f, u; int nw; bit to;
        capture(0, -1, s, w, f, u, nw, to);
        n_assert++; if (to || s !== 64'd0 || w !== WS_EXP) begin n_fail++;
            $display("FAIL underrun_frame: to=%b sd=%h ws=%h, want 0 0 %h", to, s, w, WS_EXP); end
        n_assert++; if (u !== P0_EXP || f !== P0_EXP) begin n_fail++;
            $display("FAIL underrun_flag: got ur=%h fs=%h, want %h", u, f, P0_EXP); end
        @(negedge sck);
        n_assert++; if (fs !== 1'b1 || ur !== 1'b1) begin n_fail++;
            $display("FAIL underrun_next_p0: got fs=%b ur=%b, want 1 1", fs, ur); end
        in_valid = 1'b1; in_left = 32'hDEAD_BEEF; in_right = 32'h0F1E_2D3C;
        @(negedge sck);
        in_valid = 1'b0;
        capture(0, -1, s, w, f, u, nw, to);
        n_assert++; if (to || s !== 64'hDEAD_BEEF_0F1E_2D3C) begin n_fail++;
            $display("FAIL underrun_recover_sd: to=%b got %h, want deadbeef0f1e2d3c", to, s); end
        n_assert++; if (u !== 64'd0 || nw !== 63) begin n_fail++;
            $display("FAIL underrun_recover_ur: got ur=%h wait=%0d, want 0 63", u, nw); end
    endtask

    task automatic test_back_to_back();
        go_idle();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int wt;
                    wt = 0;
                    in_valid = 1'b1; in_left = bl[i]; in_right = br[i];
                    while (in_ready !== 1'b1 && wt < 300) begin @(negedge sck); wt++; end
                    if (wt >= 300) begin
                        n_assert++; n_fail++;
                        $display("FAIL b2b_accept_timeout: pair %0d not taken", i);
                        break;
                    end
                    @(negedge sck);
                    n_assert++; if (in_ready !== 1'b0) begin n_fail++;
                        $display("FAIL b2b_ready_low: pair %0d got %b, want 0", i, in_ready); end
                end
                in_valid = 1'b0;
            end
            begin
                logic [63:0] s, w, f, u; int nw; bit to; int wt;
                wt = 0;
                while (in_ready !== 1'b0 && wt < 50) begin @(negedge sck); wt++; end
                en = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    capture(0, -1, s, w, f, u, nw, to);
                    n_assert++; if (to || s !== {bl[i], br[i]} || u !== 64'd0) begin n_fail++;
                        $display("FAIL b2b_frame%0d: to=%b sd=%h ur=%h, want %h 0",
                                 i, to, s, u, {bl[i], br[i]}); end
                end
                @(negedge sck);
                n_assert++; if (fs !== 1'b1 || ur !== 1'b1) begin n_fail++;
                    $display("FAIL b2b_no_repeat: got fs=%b ur=%b, want 1 1", fs, ur); end
            end
        join
        go_idle();
    endtask

    task automatic test_en_drop();
        logic [63:0] s, w, f, u; int nw; bit to; logic bad;
        in_valid = 1'b1; in_left = 32'h1357_9BDF; in_right = 32'h2468_ACE0;
        @(negedge sck);
        in_valid = 1'b0;
        en = 1'b1;
        capture(0, 20, s, w, f, u, nw, to);
        n_assert++; if (to || s !== 64'h1357_9BDF_2468_ACE0 || w !== WS_EXP) begin n_fail++;
            $display("FAIL endrop_frame: to=%b sd=%h ws=%h, want 13579bdf2468ace0 %h", to, s, w, WS_EXP); end
        bad = 1'b0;
        repeat (5) begin
            @(negedge sck);
            if (ws !== 1'b0 || sd !== 1'b0 || fs !== 1'b0) bad = 1'b1;
        end
        n_assert++; if (bad !== 1'b0) begin n_fail++;
            $display("FAIL endrop_idle: got activity after frame end, want ws=sd=fs=0"); end
        en = 1'b1;
        @(negedge sck);
        n_assert++; if (fs !== 1'b1 || ur !== 1'b1) begin n_fail++;
            $display("FAIL endrop_restart: got fs=%b ur=%b, want 1 1", fs, ur); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_left = 32'hFFFF_FFFF; in_right = 32'hFFFF_FFFF;
        @(negedge sck);
        in_valid = 1'b0;
        en = 1'b1;
        @(negedge sck);
        in_valid = 1'b1; in_left = 32'h0000_FFFF; in_right = 32'hFFFF_0000;
        @(negedge sck);
        in_valid = 1'b0;
        repeat (39) @(negedge sck);
        n_assert++; if (ws !== 1'b1 || sd !== 1'b1 || in_ready !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_pre: got ws=%b sd=%b rdy=%b at p40, want 1 1 0", ws, sd, in_ready); end
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_assert++; if ({ws, sd, fs, ur, in_ready} !== 5'b00001) begin n_fail++;
            $display("FAIL rstmid_async: got ws,sd,fs,ur,rdy=%b, want 00001",
                     {ws, sd, fs, ur, in_ready}); end
        @(negedge sck);
        rst = 1'b0;
        repeat (5) @(negedge sck);
        n_assert++; if ({ws, sd, fs} !== 3'b000) begin n_fail++;
            $display("FAIL rstmid_quiet: got ws,sd,fs=%b, want 000", {ws, sd, fs}); end
        en = 1'b1;
        @(negedge sck);
        n_assert++; if (fs !== 1'b1 || ur !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_hold_discarded: got fs=%b ur=%b, want 1 1", fs, ur); end
        go_idle();
    endtask

    task automatic test_dw24();
        logic [63:0] s, w, f, u; int nw; bit to;
        v2 = 1'b1; l2 = 24'hABCDEF; r2 = 24'h123456;
        @(negedge sck);
        v2 = 1'b0;
        en2 = 1'b1;
        capture(1, -1, s, w, f, u, nw, to);
        en2 = 1'b0;
        n_assert++; if (to || s !== 64'hABCD_EF00_1234_5600) begin n_fail++;
            $display("FAIL dw24_sd: to=%b got %h, want abcdef0012345600", to, s); end
        n_assert++; if (s[39:32] !== 8'h00 || s[7:0] !== 8'h00) begin n_fail++;
            $display("FAIL dw24_low_bits: got %h/%h, want 00/00", s[39:32], s[7:0]); end
        n_assert++; if (w !== WS_EXP || f !== P0_EXP || u !== 64'd0) begin n_fail++;
            $display("FAIL dw24_ctl: ws=%h fs=%h ur=%h, want %h %h 0", w, f, u, WS_EXP, P0_EXP); end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_underrun();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_dw24();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
